stereo_mixer: RTL and testbench

STEREO_MIXER -- requirements
Module: stereo_mixer

---
 rtl/stereo_mixer.sv | 132 +++++++++++++
 tb/tb_stereo_mixer.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/stereo_mixer.sv
// Multi-voice stereo mixer: one voice per cycle into wide signed accumulators, then saturating output stage.
// Frame latency NUM_CH+1 cycles; strobes arriving while busy are dropped and flagged on the sticky overrun.
module stereo_mixer #(
  parameter int NUM_CH   = 4,
  parameter int SAMPLE_W = 16
) (
  input  logic                         clk_in,
  input  logic                         rst_n_in,
  input  logic                         sample_valid_in,
  input  logic [NUM_CH*SAMPLE_W-1:0]   note_data_in,
  input  logic [2*NUM_CH-1:0]          stereo_in,
  input  logic                         stereo_on,
  input  logic [2:0]                   vol_shift_in,
  output logic [SAMPLE_W-1:0]          sample_l,
  output logic [SAMPLE_W-1:0]          sample_r,
  output logic                         sample_valid_out,
  output logic                         busy,
  output logic                         overrun
);

  localparam int IDX_W = $clog2(NUM_CH);
  localparam int ACC_W = SAMPLE_W + $clog2(NUM_CH) + 1;
  localparam logic signed [ACC_W-1:0] MAX_V = ACC_W'(2**(SAMPLE_W-1) - 1);
  localparam logic signed [ACC_W-1:0] MIN_V = ~MAX_V;

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t                     state_q, state_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic signed [ACC_W-1:0]    acc_l_q, acc_l_d, acc_r_q, acc_r_d;
  logic [NUM_CH*SAMPLE_W-1:0] notes_q, notes_d;
  logic [2*NUM_CH-1:0]        route_q, route_d;
  logic                       stereo_q, stereo_d;
  logic [2:0]                 shift_q, shift_d;
  logic [SAMPLE_W-1:0]        out_l_q, out_l_d, out_r_q, out_r_d;
  logic                       vld_q, vld_d, ovr_q, ovr_d;

  logic signed [SAMPLE_W-1:0] voice;
  logic signed [ACC_W-1:0]    voice_ext, voice_shf;
  logic [1:0]                 route_k;

  assign voice     = $signed(notes_q[int'(idx_q)*SAMPLE_W +: SAMPLE_W]);
  assign route_k   = route_q[2*int'(idx_q) +: 2];
  assign voice_ext = ACC_W'(voice);
  // Arithmetic shift on a signed operand: rounds toward minus infinity.
  assign voice_shf = voice_ext >>> shift_q;

  function automatic logic [SAMPLE_W-1:0] sat(input logic signed [ACC_W-1:0] a);
    if (a > MAX_V)      return MAX_V[SAMPLE_W-1:0];
    else if (a < MIN_V) return MIN_V[SAMPLE_W-1:0];
    else                return a[SAMPLE_W-1:0];
  endfunction

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    acc_l_d  = acc_l_q;
    acc_r_d  = acc_r_q;
    notes_d  = notes_q;
    route_d  = route_q;
    stereo_d = stereo_q;
    shift_d  = shift_q;
    out_l_d  = out_l_q;
    out_r_d  = out_r_q;
    vld_d    = 1'b0;
    ovr_d    = ovr_q | (sample_valid_in & (state_q != IDLE));
    case (state_q)
      IDLE: begin
        if (sample_valid_in) begin
          notes_d  = note_data_in;
          route_d  = stereo_in;
          stereo_d = stereo_on;
          shift_d  = vol_shift_in;
          acc_l_d  = '0;
          acc_r_d  = '0;
          idx_d    = '0;
          state_d  = ACCUM;
        end
      end
      ACCUM: begin
        if (!stereo_q || route_k[1]) acc_l_d = acc_l_q + voice_shf;
        if (!stereo_q || route_k[0]) acc_r_d = acc_r_q + voice_shf;
        if (idx_q == IDX_W'(NUM_CH - 1)) state_d = DONE;
        else                             idx_d   = idx_q + 1'b1;
      end
      DONE: begin
        out_l_d = sat(acc_l_q);
        out_r_d = sat(acc_r_q);
        vld_d   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      acc_l_q  <= '0;
      acc_r_q  <= '0;
      notes_q  <= '0;
      route_q  <= '0;
      stereo_q <= 1'b0;
      shift_q  <= '0;
      out_l_q  <= '0;
      out_r_q  <= '0;
      vld_q    <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      acc_l_q  <= acc_l_d;
      acc_r_q  <= acc_r_d;
      notes_q  <= notes_d;
      route_q  <= route_d;
      stereo_q <= stereo_d;
      shift_q  <= shift_d;
      out_l_q  <= out_l_d;
      out_r_q  <= out_r_d;
      vld_q    <= vld_d;
      ovr_q    <= ovr_d;
    end
  end

  assign sample_l         = out_l_q;
  assign sample_r         = out_r_q;
  assign sample_valid_out = vld_q;
  assign busy             = (state_q != IDLE);
  assign overrun          = ovr_q;

endmodule

// File: tb/tb_stereo_mixer.sv
// Directed bench for stereo_mixer at default parameters (4 voices, 16-bit samples).
module tb_stereo_mixer;

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic        sample_valid_in;
  logic [63:0] note_data_in;
  logic [7:0]  stereo_in;
  logic        stereo_on;
  logic [2:0]  vol_shift_in;
  logic [15:0] sample_l, sample_r;
  logic        sample_valid_out, busy, overrun;

  int checks = 0;
  int errors = 0;

  stereo_mixer #(.NUM_CH(4), .SAMPLE_W(16)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .sample_valid_in(sample_valid_in),
    .note_data_in(note_data_in), .stereo_in(stereo_in), .stereo_on(stereo_on),
    .vol_shift_in(vol_shift_in), .sample_l(sample_l), .sample_r(sample_r),
    .sample_valid_out(sample_valid_out), .busy(busy), .overrun(overrun)
  );

  always #5 clk_in = ~clk_in;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Strobe one frame at a negedge, then expect the result 5 cycles after the capturing edge.
  task automatic run_frame(input string tag, input logic [63:0] notes, input logic [7:0] st,
                           input logic on, input logic [2:0] sh,
                           input logic [15:0] exp_l, input logic [15:0] exp_r);
    int lat;
    @(negedge clk_in);
    note_data_in = notes; stereo_in = st; stereo_on = on; vol_shift_in = sh;
    sample_valid_in = 1'b1;
    @(negedge clk_in);
    sample_valid_in = 1'b0;
    note_data_in = 64'h5555_AAAA_1234_4321;
    stereo_in = ~st; stereo_on = ~on; vol_shift_in = 3'd7;
    check_val({tag, "_busy"}, 32'(busy), 32'd1);
    lat = -1;
    for (int c = 1; c <= 20; c++) begin
      if (sample_valid_out) begin lat = c - 1; break; end
      @(negedge clk_in);
    end
    check_val({tag, "_lat"}, 32'(lat), 32'd5);
    check_val({tag, "_l"}, 32'(sample_l), 32'(exp_l));
    check_val({tag, "_r"}, 32'(sample_r), 32'(exp_r));
    @(negedge clk_in);
    check_val({tag, "_vld_drop"}, 32'(sample_valid_out), 32'd0);
    repeat (2) @(negedge clk_in);
    check_val({tag, "_hold_l"}, 32'(sample_l), 32'(exp_l));
    check_val({tag, "_hold_r"}, 32'(sample_r), 32'(exp_r));
  endtask

  // Frame strobe, then a second strobe extra_at cycles later which must be dropped.
  task automatic run_drop(input string tag, input int extra_at,
                          input logic [15:0] exp_l, input logic [15:0] exp_r);
    int pulses = 0;
    logic [15:0] got_l = 16'h0, got_r = 16'h0;
    @(negedge clk_in);
    note_data_in = {16'd4000, 16'd3000, 16'd2000, 16'd1000};
    stereo_in = 8'b00_11_10_01; stereo_on = 1'b1; vol_shift_in = 3'd0;
    sample_valid_in = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk_in);
      if (sample_valid_out) begin pulses++; got_l = sample_l; got_r = sample_r; end
      sample_valid_in = (c == extra_at);
      if (c == 1) note_data_in = 64'h7FFF_7FFF_7FFF_7FFF;
    end
    sample_valid_in = 1'b0;
    check_val({tag, "_pulses"}, 32'(pulses), 32'd1);
    check_val({tag, "_l"}, 32'(got_l), 32'(exp_l));
    check_val({tag, "_r"}, 32'(got_r), 32'(exp_r));
    check_val({tag, "_ovr"}, 32'(overrun), 32'd1);
  endtask

  initial begin
    int pulses;
    rst_n_in = 1'b0; sample_valid_in = 1'b0; note_data_in = '0;
    stereo_in = '0; stereo_on = 1'b1; vol_shift_in = '0;
    repeat (3) @(negedge clk_in);
    check_val("rst_l", 32'(sample_l), 32'd0);
    check_val("rst_r", 32'(sample_r), 32'd0);
    check_val("rst_vld", 32'(sample_valid_out), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_ovr", 32'(overrun), 32'd0);
    rst_n_in = 1'b1;

    run_frame("stereo", {16'd4000, 16'd3000, 16'd2000, 16'd1000}, 8'b00_11_10_01, 1'b1, 3'd0,
              16'd5000, 16'd4000);
    run_frame("mono", {16'd4000, 16'd3000, 16'd2000, 16'd1000}, 8'b00_11_10_01, 1'b0, 3'd0,
              16'd10000, 16'd10000);
    run_frame("sat_pos", 64'h7FFF_7FFF_7FFF_7FFF, 8'hFF, 1'b1, 3'd0, 16'h7FFF, 16'h7FFF);
    run_frame("sat_neg", 64'h8000_8000_8000_8000, 8'hFF, 1'b1, 3'd0, 16'h8000, 16'h8000);
    run_frame("atten", {16'h0000, 16'h0008, 16'hFFFB, 16'hFFFF}, 8'hFF, 1'b1, 3'd2,
              16'hFFFF, 16'hFFFF);
    check_val("no_ovr_yet", 32'(overrun), 32'd0);

    run_drop("ovr_busy", 2, 16'd5000, 16'd4000);
    run_frame("after_ovr", {16'd1, 16'd2, 16'd3, 16'd4}, 8'b11_11_11_11, 1'b1, 3'd0,
              16'd10, 16'd10);
    check_val("ovr_sticky", 32'(overrun), 32'd1);

    @(negedge clk_in);
    rst_n_in = 1'b0;
    @(negedge clk_in);
    rst_n_in = 1'b1;
    check_val("ovr_cleared", 32'(overrun), 32'd0);
    run_drop("ovr_done", 5, 16'd5000, 16'd4000);

    // Reset two cycles into a frame; outputs currently hold 5000/4000.
    @(negedge clk_in);
    note_data_in = {16'd4000, 16'd3000, 16'd2000, 16'd1000};
    stereo_in = 8'hFF; stereo_on = 1'b1; vol_shift_in = 3'd0;
    sample_valid_in = 1'b1;
    @(negedge clk_in);
    sample_valid_in = 1'b0;
    @(negedge clk_in);
    rst_n_in = 1'b0;
    #1;
    check_val("midrst_l", 32'(sample_l), 32'd0);
    check_val("midrst_r", 32'(sample_r), 32'd0);
    check_val("midrst_busy", 32'(busy), 32'd0);
    check_val("midrst_ovr", 32'(overrun), 32'd0);
    @(negedge clk_in);
    rst_n_in = 1'b1;
    pulses = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk_in);
      if (sample_valid_out) pulses++;
    end
    check_val("midrst_no_vld", 32'(pulses), 32'd0);
    run_frame("post_rst", {16'd4000, 16'd3000, 16'd2000, 16'd1000}, 8'b00_11_10_01, 1'b1, 3'd0,
              16'd5000, 16'd4000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
